risc_v_rf_port_ctrl: RTL and testbench

Client-side controller for the two-read/one-write RISC-V register file. It drives the file's wr/waddr/wdata and re1/raddr1/re2/raddr2 ports and consumes rdata1/rdata2. Operand-fetch requests arrive on a valid/ready interface and are stalled on read-after-write hazards. Writebacks are buffered in an in-order FIFO that drains one entry per cycle into the file.

---
 rtl/risc_v_rf_port_ctrl_if.sv | 30 +++
 rtl/risc_v_rf_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_risc_v_rf_port_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_v_rf_port_ctrl_if.sv
// Operand-request, operand-response and writeback handshakes between the pipeline
// and the register-file port controller.
interface risc_v_rf_port_ctrl_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_rs1;
  logic [4:0]      req_rs2;
  logic            req_use1;
  logic            req_use2;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_op1;
  logic [XLEN-1:0] rsp_op2;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output req_valid, req_rs1, req_rs2, req_use1, req_use2, rsp_ready,
           wb_valid, wb_rd, wb_data,
    input  req_ready, rsp_valid, rsp_op1, rsp_op2, wb_ready
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_use1, req_use2, rsp_ready,
           wb_valid, wb_rd, wb_data,
    output req_ready, rsp_valid, rsp_op1, rsp_op2, wb_ready
  );
endinterface

// File: rtl/risc_v_rf_port_ctrl.sv
// Client-side controller for a 2R/1W register file: hazard-stalled operand fetch
// plus an in-order writeback FIFO draining one entry per cycle.
//   state | meaning
//   IDLE  | ready for a new operand request
//   WAIT  | hold while a pending writeback targets an effective source
//   READ  | drive read enables/addresses
//   CAPT  | register read data into the operand outputs
//   RESP  | present operands until the consumer takes them
module risc_v_rf_port_ctrl #(
  parameter int XLEN     = 32,
  parameter int WB_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  risc_v_rf_port_ctrl_if.slave  bus,
  output logic                  wr,
  output logic [4:0]            waddr,
  output logic [XLEN-1:0]       wdata,
  output logic                  re1,
  output logic [4:0]            raddr1,
  input  logic [XLEN-1:0]       rdata1,
  output logic                  re2,
  output logic [4:0]            raddr2,
  input  logic [XLEN-1:0]       rdata2,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(WB_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT, READ, CAPT, RESP} state_t;
  state_t state_q, state_d;

  logic [4:0]      fifo_rd   [WB_DEPTH];
  logic [XLEN-1:0] fifo_data [WB_DEPTH];
  logic [PTR_W-1:0] head, tail, off;
  logic [PTR_W:0]   count;
  logic push, pop, hazard;

  logic [4:0]      rs1_q, rs2_q;
  logic            eff1_q, eff2_q;
  logic [XLEN-1:0] op1_q, op2_q;

  // Writes to x0 are acknowledged but never reach the file.
  assign bus.wb_ready = (count != CNT_FULL);
  assign push  = bus.wb_valid && bus.wb_ready && (bus.wb_rd != 5'd0);
  assign pop   = (count != '0);
  assign wr    = pop;
  assign waddr = pop ? fifo_rd[head]   : '0;
  assign wdata = pop ? fifo_data[head] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= bus.wb_rd;
      fifo_data[tail] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Only registered entries count; a writeback arriving on the WAIT->READ edge is younger.
  always_comb begin
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      off = PTR_W'(i) - head;
      if (({1'b0, off} < count) &&
          ((eff1_q && (fifo_rd[i] == rs1_q)) || (eff2_q && (fifo_rd[i] == rs2_q))))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    re1           = 1'b0;
    re2           = 1'b0;
    raddr1        = '0;
    raddr2        = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = WAIT;
      end
      WAIT: if (!hazard) state_d = READ;
      READ: begin
        re1     = eff1_q;
        re2     = eff2_q;
        raddr1  = eff1_q ? rs1_q : 5'd0;
        raddr2  = eff2_q ? rs2_q : 5'd0;
        state_d = CAPT;
      end
      CAPT: state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      eff1_q    <= 1'b0;
      eff2_q    <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      stall_cnt <= '0;
    end else begin
      if (state_q == IDLE && bus.req_valid) begin
        rs1_q  <= bus.req_rs1;
        rs2_q  <= bus.req_rs2;
        eff1_q <= bus.req_use1 && (bus.req_rs1 != 5'd0);
        eff2_q <= bus.req_use2 && (bus.req_rs2 != 5'd0);
      end
      if (state_q == CAPT) begin
        op1_q <= eff1_q ? rdata1 : '0;
        op2_q <= eff2_q ? rdata2 : '0;
      end
      if (state_q == WAIT && hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.rsp_op1 = op1_q;
  assign bus.rsp_op2 = op2_q;
endmodule

// File: tb/tb_risc_v_rf_port_ctrl.sv
// Bench for risc_v_rf_port_ctrl: behavioural register file, reference register
// image, and scoreboards for write order and operand responses.
module tb_risc_v_rf_port_ctrl;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  risc_v_rf_port_ctrl_if #(.XLEN(XLEN)) bus();

  logic            wr, re1, re2;
  logic [4:0]      waddr, raddr1, raddr2;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata1 = '0;
  logic [XLEN-1:0] rdata2 = '0;
  logic [15:0]     stall_cnt;

  risc_v_rf_port_ctrl #(.XLEN(XLEN), .WB_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .wr(wr), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .stall_cnt(stall_cnt)
  );

  // Register file: writes commit at the edge, reads return pre-write data one cycle later.
  logic [XLEN-1:0] rf [32] = '{default: '0};
  always @(posedge clk) begin
    if (wr)  rf[waddr] <= wdata;
    if (re1) rdata1 <= rf[raddr1];
    if (re2) rdata2 <= rf[raddr2];
  end

  typedef struct packed { logic [4:0] rd; logic [XLEN-1:0] data; } wbe_t;
  typedef struct packed { logic [XLEN-1:0] op1; logic [XLEN-1:0] op2; } rsp_t;
  wbe_t wr_q[$];
  rsp_t rsp_q[$];
  logic [XLEN-1:0] ref_rf [32] = '{default: '0};
  wbe_t mon_e;
  rsp_t mon_r;

  int total = 0, bad = 0;
  int wr_cnt = 0, re1_cnt = 0, re2_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Committed image overlaid with still-pending writebacks in order.
  function automatic logic [XLEN-1:0] ref_val(input logic [4:0] r);
    logic [XLEN-1:0] v;
    v = ref_rf[r];
    foreach (wr_q[i]) if (wr_q[i].rd == r) v = wr_q[i].data;
    return (r == 5'd0) ? '0 : v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      wr_q.delete();
      rsp_q.delete();
    end else begin
      if (wr) begin
        wr_cnt++;
        if (wr_q.size() == 0) check("wr_unexpected", wr, 0);
        else begin
          mon_e = wr_q.pop_front();
          check("wr_addr", waddr, mon_e.rd);
          check("wr_data", wdata, mon_e.data);
          ref_rf[mon_e.rd] = mon_e.data;
        end
      end
      if (re1) re1_cnt++;
      if (re2) re2_cnt++;
      if (bus.wb_valid && bus.wb_ready && bus.wb_rd != 5'd0)
        wr_q.push_back('{bus.wb_rd, bus.wb_data});
      if (bus.req_valid && bus.req_ready) begin
        mon_r.op1 = bus.req_use1 ? ref_val(bus.req_rs1) : '0;
        mon_r.op2 = bus.req_use2 ? ref_val(bus.req_rs2) : '0;
        rsp_q.push_back(mon_r);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", bus.rsp_valid, 0);
        else begin
          mon_r = rsp_q.pop_front();
          check("rsp_op1", bus.rsp_op1, mon_r.op1);
          check("rsp_op2", bus.rsp_op2, mon_r.op2);
        end
      end
    end
  end

  task automatic do_req(input logic [4:0] a, input logic [4:0] b, input logic u1, input logic u2,
                        input logic wv, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                        output int lat);
    int n;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_rs1 = a; bus.req_rs2 = b;
    bus.req_use1 = u1; bus.req_use2 = u2;
    bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.wb_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 100);
    check("rsp_timeout", bus.rsp_valid, 1);
  endtask

  task automatic wb_put(input logic [4:0] rd, input logic [XLEN-1:0] d, output int waits);
    @(posedge clk); #1;
    bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
    waits = 0;
    @(negedge clk);
    while (!bus.wb_ready && waits < 100) begin @(negedge clk); waits++; end
  endtask

  task automatic wb_idle();
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, w, wsum, s0, w0, r1, r2;
    rsp_t exp;
    bus.req_valid = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_use1 = 0; bus.req_use2 = 0;
    bus.rsp_ready = 1; bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_wb_ready", bus.wb_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_wr", wr, 0);
    check("rst_re", {re1, re2}, 0);
    check("rst_addr", {waddr, raddr1, raddr2}, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_ops", {bus.rsp_op1, bus.rsp_op2}, 0);
    reset = 1'b1;

    // empty file read, hazard-free latency
    r1 = re1_cnt;
    do_req(5'd2, 5'd3, 1, 1, 0, 5'd0, '0, lat);
    check("lat_nohazard", lat, 4);
    #2 check("re1_pulses", re1_cnt - r1, 1);

    // RAW hazard against the head being written
    s0 = stall_cnt;
    do_req(5'd2, 5'd2, 1, 1, 1, 5'd2, 32'habcd, lat);
    check("lat_hazard_ge5", lat >= 5, 1);
    check("stall_incr", stall_cnt > s0, 1);

    // x0 handling
    @(posedge clk); #2 w0 = wr_cnt;
    wb_put(5'd0, 32'h1234, w);
    wb_idle();
    repeat (3) @(posedge clk);
    #2 check("x0_no_wr", wr_cnt - w0, 0);
    wb_put(5'd15, 32'h1234, w);
    wb_idle();
    r1 = re1_cnt; r2 = re2_cnt;
    do_req(5'd0, 5'd15, 1, 1, 0, 5'd0, '0, lat);
    #2;
    check("x0_re1_idle", re1_cnt - r1, 0);
    check("x0_re2_once", re2_cnt - r2, 1);

    // back-to-back writebacks drain in order without backpressure
    wsum = 0;
    for (int i = 6; i <= 9; i++) begin
      wb_put(5'(i), 32'h12340 + i, w);
      wsum += w;
    end
    wb_idle();
    check("wb_stream_waits", wsum, 0);
    repeat (3) @(posedge clk);
    #2 check("wr_drained", wr_q.size(), 0);
    do_req(5'd6, 5'd7, 1, 1, 0, 5'd0, '0, lat);
    do_req(5'd8, 5'd9, 1, 1, 0, 5'd0, '0, lat);

    // response backpressure with writebacks draining meanwhile
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    do_req(5'd6, 5'd8, 1, 1, 0, 5'd0, '0, lat);
    #2;
    w0 = wr_cnt;
    exp = rsp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.wb_valid = (i < 2);
      bus.wb_rd = 5'(10 + i);
      bus.wb_data = 32'hbeef0 + i;
      @(negedge clk);
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_op1", bus.rsp_op1, exp.op1);
      check("bp_op2", bus.rsp_op2, exp.op2);
    end
    @(posedge clk); #2 check("bp_wb_drain", wr_cnt - w0, 2);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", bus.req_ready, 1);
    check("bp_idle_valid", bus.rsp_valid, 0);
    do_req(5'd10, 5'd11, 1, 1, 0, 5'd0, '0, lat);

    // reset while stalled in WAIT with a pending writeback
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_rs1 = 5'd20; bus.req_use1 = 1'b1;
    bus.req_rs2 = 5'd0; bus.req_use2 = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'h5555;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.wb_valid = 1'b0;
    check("mid_busy", bus.req_ready, 0);
    check("mid_wr_pending", wr, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_wr", wr, 0);
    check("mid_rst_wb_ready", bus.wb_ready, 1);
    check("mid_rst_req_ready", bus.req_ready, 1);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_stall", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 w0 = wr_cnt;
    repeat (4) @(posedge clk);
    #2 check("mid_no_wr", wr_cnt - w0, 0);
    do_req(5'd20, 5'd0, 1, 0, 0, 5'd0, '0, lat);
    check("mid_lat", lat, 4);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
